log_capture_ram: RTL and testbench

- Parametrised multi-channel logging memory that replaces the fixed two-half-word capture RAM behind the register file.
- Captures NB_CHANNELS parallel samples per valid strobe into per-channel RAMs of 2^NB_ADDR entries.
- Three capture modes: one-shot fill, pre/post-trigger circular, and continuous circular.
- Micro reads any channel and address through a registered read port; status flags go to the register file and LEDs.

---
 rtl/log_capture_ram.sv | 183 ++++++++++++++++++
 tb/tb_log_capture_ram.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/log_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : log_capture_ram
// Purpose  : Multi-channel logging RAM. It supports one-shot, pre/post-trigger
//            circular and continuous circular capture, and has a registered
//            read port.
// Options  : LOG_CAPTURE_DECIM_EN adds i_decim (keep every (i_decim+1)-th valid)
// Revision : 1.0 - initial release
// ============================================================================
module log_capture_ram #(
  parameter int NB_DATA     = 16,
  parameter int NB_CHANNELS = 2,
  parameter int NB_ADDR     = 11,
  parameter int NB_SEL      = 1
) (
  input  logic                           clock,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic [NB_CHANNELS*NB_DATA-1:0] i_data,
  input  logic                           i_run,
  input  logic [1:0]                     i_mode,
  input  logic                           i_trigger,
  input  logic [NB_ADDR-1:0]             i_post_len,
`ifdef LOG_CAPTURE_DECIM_EN
  input  logic [7:0]                     i_decim,
`endif
  input  logic [NB_ADDR-1:0]             i_rd_addr,
  input  logic [NB_SEL-1:0]              i_rd_ch,
  output logic [NB_DATA-1:0]             o_rd_data,
  output logic                           o_full,
  output logic                           o_busy,
  output logic                           o_triggered,
  output logic [NB_ADDR-1:0]             o_wr_ptr,
  output logic [1:0]                     o_state
);

  localparam int                c_DEPTH         = 2 ** NB_ADDR;
  localparam logic [NB_SEL:0]   c_NCH           = (NB_SEL + 1)'(NB_CHANNELS);
  localparam logic [1:0]        c_MODE_ONESHOT  = 2'd0;
  localparam logic [1:0]        c_MODE_TRIG     = 2'd1;
  localparam logic [NB_ADDR-1:0] c_ONE          = NB_ADDR'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_busy;
  logic                 r_run_d;
  logic                 r_full;
  logic                 r_triggered;
  logic [NB_ADDR-1:0]   r_wr_ptr;
  logic [NB_ADDR-1:0]   r_post_len;
  logic [NB_ADDR-1:0]   r_post_cnt;
  logic [1:0]           r_mode;
  logic [NB_DATA-1:0]   r_rd_data;
  logic [NB_DATA-1:0]   r_mem [NB_CHANNELS][c_DEPTH];

  logic w_arm;
  logic w_accept;
  logic w_trig_ev;
  logic w_wr_en;
  logic w_last;
  logic w_capturing;

`ifdef LOG_CAPTURE_DECIM_EN
  logic [7:0] r_decim;
  logic [7:0] r_dcnt;

  // Only decimated samples count; a trigger must coincide with a kept sample.
  assign w_accept  = i_valid && (r_dcnt == 8'd0);
  assign w_trig_ev = i_trigger && w_accept;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_decim <= 8'd0;
      r_dcnt  <= 8'd0;
    end else if (w_arm) begin
      r_decim <= i_decim;
      r_dcnt  <= 8'd0;
    end else if (w_capturing && i_run && i_valid) begin
      r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
    end
  end
`else
  assign w_accept  = i_valid;
  assign w_trig_ev = i_trigger;
`endif

  assign w_capturing = (r_state == ST_FILL) || (r_state == ST_POST);
  assign w_arm       = (r_state == ST_IDLE) && i_run && !r_run_d;
  assign w_wr_en     = w_capturing && i_run && w_accept;
  assign w_last      = (r_wr_ptr == '1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arm) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (!i_run) begin
          w_state_nxt = ST_IDLE;
        end else if (r_mode == c_MODE_ONESHOT) begin
          if (w_wr_en && w_last) w_state_nxt = ST_DONE;
        end else if (r_mode == c_MODE_TRIG && w_trig_ev) begin
          w_state_nxt = (r_post_len == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (!i_run) w_state_nxt = ST_IDLE;
        else if (w_wr_en && r_post_cnt == c_ONE) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (!i_run) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_run_d     <= 1'b0;
      r_full      <= 1'b0;
      r_triggered <= 1'b0;
      r_wr_ptr    <= '0;
      r_post_len  <= '0;
      r_post_cnt  <= '0;
      r_mode      <= c_MODE_ONESHOT;
    end else begin
      r_run_d <= i_run;
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_POST);
      if (w_arm) begin
        r_wr_ptr    <= '0;
        r_full      <= 1'b0;
        r_triggered <= 1'b0;
        r_mode      <= (i_mode == 2'd3) ? c_MODE_ONESHOT : i_mode;
        r_post_len  <= i_post_len;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + c_ONE;
          if (w_last) r_full <= 1'b1;
          if (r_state == ST_POST) r_post_cnt <= r_post_cnt - c_ONE;
        end
        if (r_state == ST_FILL && i_run && r_mode == c_MODE_TRIG && w_trig_ev) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= r_post_len;
        end
      end
    end
  end

  // RAM array is never reset so it can map onto block memory.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int k = 0; k < NB_CHANNELS; k++) begin
        r_mem[k][r_wr_ptr] <= i_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if ({1'b0, i_rd_ch} < c_NCH) begin
      r_rd_data <= r_mem[i_rd_ch][i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_full      = r_full;
  assign o_busy      = r_busy;
  assign o_triggered = r_triggered;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_log_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_capture_ram
// Purpose  : Self-checking bench for log_capture_ram using directed scenarios
//            and random traffic checked against a behavioural capture model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_log_capture_ram;

  localparam int NB_DATA = 16;
  localparam int NB_CH   = 2;
  localparam int NB_ADDR = 4;
  localparam int NB_SEL  = 1;
  localparam int DEPTH   = 16;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      valid = 1'b0;
  logic [NB_CH*NB_DATA-1:0]  data  = '0;
  logic                      run   = 1'b0;
  logic [1:0]                mode  = 2'd0;
  logic                      trigger = 1'b0;
  logic [NB_ADDR-1:0]        post_len = '0;
  logic [NB_ADDR-1:0]        rd_addr = '0;
  logic [NB_SEL-1:0]         rd_ch = '0;
`ifdef LOG_CAPTURE_DECIM_EN
  logic [7:0]                decim = 8'd0;
`endif
  logic [NB_DATA-1:0]        o_rd_data;
  logic                      o_full, o_busy, o_triggered;
  logic [NB_ADDR-1:0]        o_wr_ptr;
  logic [1:0]                o_state;

  always #5 clock = ~clock;

  log_capture_ram #(
    .NB_DATA(NB_DATA), .NB_CHANNELS(NB_CH), .NB_ADDR(NB_ADDR), .NB_SEL(NB_SEL)
  ) dut (
    .clock(clock), .i_reset(reset), .i_valid(valid), .i_data(data),
    .i_run(run), .i_mode(mode), .i_trigger(trigger), .i_post_len(post_len),
`ifdef LOG_CAPTURE_DECIM_EN
    .i_decim(decim),
`endif
    .i_rd_addr(rd_addr), .i_rd_ch(rd_ch), .o_rd_data(o_rd_data),
    .o_full(o_full), .o_busy(o_busy), .o_triggered(o_triggered),
    .o_wr_ptr(o_wr_ptr), .o_state(o_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0=IDLE 1=FILL 2=POST 3=DONE
  int          m_state = 0, m_ptr = 0, m_mode = 0, m_post = 0, m_left = 0;
  bit          m_full = 0, m_trig = 0, m_run_d = 0, m_rd_known = 1;
  logic [15:0] m_rd = '0;
  logic [15:0] m_mem [NB_CH][DEPTH];
  bit          m_wr  [NB_CH][DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int s;
    if (int'(rd_ch) < NB_CH) begin
      m_rd       = m_mem[rd_ch][rd_addr];
      m_rd_known = m_wr[rd_ch][rd_addr];
    end else begin
      m_rd = '0;
      m_rd_known = 1;
    end
    if (reset) begin
      m_rd = '0; m_rd_known = 1;
      m_state = 0; m_ptr = 0; m_full = 0; m_trig = 0; m_run_d = 0;
      return;
    end
    s = m_state;
    if (s == 0 && run && !m_run_d) begin
      m_state = 1; m_ptr = 0; m_full = 0; m_trig = 0;
      m_mode = (mode == 2'd3) ? 0 : int'(mode);
      m_post = int'(post_len);
    end else if (s != 0 && !run) begin
      m_state = 0;
    end else if (s == 1 || s == 2) begin
      if (valid) begin
        for (int k = 0; k < NB_CH; k++) begin
          m_mem[k][m_ptr] = data[k*NB_DATA +: NB_DATA];
          m_wr[k][m_ptr]  = 1;
        end
        if (m_ptr == DEPTH - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (s == 2) begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end else if (m_mode == 0 && m_ptr == 0) begin
          m_state = 3;
        end
      end
      if (s == 1 && m_mode == 1 && trigger) begin
        m_trig = 1;
        if (m_post == 0) m_state = 3;
        else begin m_state = 2; m_left = m_post; end
      end
    end
    m_run_d = run;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("state",   32'(o_state),     32'(m_state));
    chk("busy",    32'(o_busy),      32'(m_state == 1 || m_state == 2));
    chk("full",    32'(o_full),      32'(m_full));
    chk("trig",    32'(o_triggered), 32'(m_trig));
    chk("wr_ptr",  32'(o_wr_ptr),    32'(m_ptr));
    if (m_rd_known) chk("rd_data", 32'(o_rd_data), 32'(m_rd));
  endtask

  task automatic sample(input int n, input bit trg);
    valid   = 1'b1;
    data    = {16'(32'h100 + n), 16'(n)};
    trigger = trg;
    tick();
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_rd",    32'(o_rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // Mode 0 one-shot fill
    mode = 2'd0; run = 1'b1;
    tick();
    for (int n = 0; n < 16; n++) sample(n, 1'b0);
    valid = 1'b0;
    chk("m0_state", 32'(o_state), 32'd3);
    chk("m0_full",  32'(o_full), 32'd1);
    chk("m0_ptr",   32'(o_wr_ptr), 32'd0);
    rd_ch = 1'b0; rd_addr = 4'd5;
    tick();
    chk("m0_rd_ch0", 32'(o_rd_data), 32'h0005);
    rd_ch = 1'b1;
    tick();
    chk("m0_rd_ch1", 32'(o_rd_data), 32'h0105);

    // Mode 1, post_len 3, trigger with sample 9
    run = 1'b0; tick();
    mode = 2'd1; post_len = 4'd3; run = 1'b1; tick();
    for (int n = 0; n < 20; n++) sample(n, n == 9);
    valid = 1'b0; trigger = 1'b0;
    chk("m1_state", 32'(o_state), 32'd3);
    chk("m1_trig",  32'(o_triggered), 32'd1);
    chk("m1_full",  32'(o_full), 32'd0);
    chk("m1_ptr",   32'(o_wr_ptr), 32'd13);

    // Mode 1, post_len 0, trigger without a sample
    run = 1'b0; tick();
    post_len = 4'd0; run = 1'b1; tick();
    for (int n = 0; n < 3; n++) sample(n + 32, 1'b0);
    valid = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("m1z_state", 32'(o_state), 32'd3);
    chk("m1z_ptr",   32'(o_wr_ptr), 32'd3);

    // Mode 2 continuous, 40 samples then release
    run = 1'b0; tick();
    mode = 2'd2; run = 1'b1; tick();
    for (int n = 0; n < 40; n++) begin
      sample(n + 64, 1'b1);
      if (n == 14) chk("m2_notfull15", 32'(o_full), 32'd0);
      if (n == 15) chk("m2_full16",    32'(o_full), 32'd1);
    end
    valid = 1'b0; trigger = 1'b0;
    chk("m2_state", 32'(o_state), 32'd1);
    chk("m2_ptr",   32'(o_wr_ptr), 32'd8);
    run = 1'b0; tick();
    chk("m2_rel_state", 32'(o_state), 32'd0);
    chk("m2_rel_full",  32'(o_full), 32'd1);
    chk("m2_rel_ptr",   32'(o_wr_ptr), 32'd8);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 24) == 0) run = ~run;
      mode     = 2'($urandom_range(0, 3));
      post_len = 4'($urandom_range(0, 15));
      valid    = 1'($urandom_range(0, 1));
      trigger  = ($urandom_range(0, 9) == 0);
      data     = 32'($urandom);
      rd_addr  = 4'($urandom_range(0, 15));
      rd_ch    = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset during POST
    reset = 1'b0; run = 1'b0; valid = 1'b0; trigger = 1'b0;
    tick(); tick();
    mode = 2'd1; post_len = 4'd10; run = 1'b1; tick();
    for (int n = 0; n < 6; n++) begin
      valid = 1'b1; data = {16'(32'hB0 + n), 16'(32'hA0 + n)}; trigger = (n == 3);
      tick();
    end
    valid = 1'b0; trigger = 1'b0;
    chk("rp_post", 32'(o_state), 32'd2);
    reset = 1'b1; run = 1'b0;
    tick();
    chk("rp_state", 32'(o_state), 32'd0);
    chk("rp_busy",  32'(o_busy), 32'd0);
    chk("rp_full",  32'(o_full), 32'd0);
    chk("rp_trig",  32'(o_triggered), 32'd0);
    chk("rp_ptr",   32'(o_wr_ptr), 32'd0);
    chk("rp_rd",    32'(o_rd_data), 32'd0);
    reset = 1'b0; rd_ch = 1'b0; rd_addr = 4'd1;
    tick();
    chk("rp_ram_kept", 32'(o_rd_data), 32'h00A1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
